spawn_scheduler: RTL and testbench
==================================

// Module: spawn_scheduler
// PURPOSE
//  Sequences enemy spawns into game_design (AUTO_SPAWN=0): times each spawn, picks x from an LFSR,
//  drives the enemy_spawn/enemy_init_x/enemy_init_y inputs, and confirms a slot was taken.
//  Spawn rate rises with score. Sits between the game top level and game_design; replaces bench-driven spawning.
// PARAMETERS
//  BASE_INTERVAL  64     cycles between spawns at score 0 (16-bit)
//  MIN_INTERVAL   8      floor on spawn interval; must be >=1
//  SCORE_SHIFT    2      interval reduction = score >> SCORE_SHIFT
//  FIELD_W        20     playfield width; x range 0..FIELD_W-1 (<=32)
//  SPAWN_Y        4'd0   enemy_init_y value for every spawn
//  ACK_TIMEOUT    4      cycles to wait for an enemy slot to go active
//  LFSR_SEED      8'hA5  LFSR reset value, nonzero
// PORTS
//  clk            in   1  system clock, rising edge
//  rst            in   1  reset, asynchronous, active-high
//  en             in   1  scheduler run enable (level)
//  score          in   8  current score from game_design
//  enemy_active   in   3  {enemy2_active, enemy1_active, enemy0_active}
//  enemy_spawn    out  1  one-cycle spawn request to game_design
//  enemy_init_x   out  5  spawn x; held stable from the SPAWN cycle until the next spawn
//  enemy_init_y   out  4  spawn y (=SPAWN_Y)
//  spawn_count    out  8  confirmed spawns, saturates at 255
//  drop_count     out  8  unconfirmed spawns (timeout), saturates at 255
//  busy           out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, timer=0, lfsr=LFSR_SEED, all outputs 0 (enemy_init_y=0 until first spawn).
//  All outputs registered; no combinational input->output path.
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4; shifts every cycle while en=1, holds when en=0.
//  x calc: r=lfsr[4:0]; x = (r>=FIELD_W) ? r-FIELD_W : r. Latched into enemy_init_x on COUNT->SPAWN.
//  Interval: d=score>>SCORE_SHIFT; I = (BASE_INTERVAL > MIN_INTERVAL+d) ? BASE_INTERVAL-d : MIN_INTERVAL.
//    Computed in 16 bits; sampled at each timer reload.
//  FSM:
//   IDLE : en=1 -> COUNT, timer<=I-1.
//   COUNT: timer>0 -> timer--. timer==0 & ~&enemy_active -> SPAWN, latch x, y, snap<=popcount(active).
//          timer==0 & all 3 active -> stay; stall until a slot frees (no extra delay after it frees).
//   SPAWN: enemy_spawn=1 for exactly this one cycle -> ACK, ack_t<=ACK_TIMEOUT-1.
//   ACK  : popcount(enemy_active) > snap -> spawn_count++, COUNT, timer<=I-1.
//          else ack_t==0 -> drop_count++, COUNT, timer<=I-1. else ack_t--.
//  First spawn: en sampled high at edge N -> enemy_spawn high after edge N+I.
//  en=0 in any state -> IDLE on next edge; enemy_spawn low; counters and x hold; timer restarts on re-enable.
//  A slot freed by a hit during ACK, same cycle as the new slot filling: popcount is unchanged,
//    so the ACK times out and drop_count counts it. This is accepted, not a bug.
//  Counters saturate at 255; they never wrap.
//  rst mid-operation: immediate return to reset values, including an enemy_spawn pulse in flight.
// TESTING
//  T1 en=1 score=0 active=000 -> first enemy_spawn exactly 64 cycles after en edge; width 1 cycle; y=0.
//  T2 score=200 (d=50) -> spawn-to-spawn period = 14 + ack latency; score=255 -> I clamps to 8.
//  T3 active=111 at timer expiry -> no pulse; drop active to 110 -> enemy_spawn next cycle.
//  T4 model sets one active bit 1 cycle after the pulse -> spawn_count +1, drop_count 0;
//     no model response -> drop_count +1 after ACK_TIMEOUT cycles.
//  T5 1000 spawns from seed A5 -> every enemy_init_x in 0..19; sequence matches reference LFSR model.
//  T6 en=0 during COUNT, or rst during SPAWN -> busy=0 next edge, no pulse, counters hold/clear per rule.

Source files
------------

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: times enemy spawns, picks LFSR-based x, and confirms slot uptake with a timeout.
module spawn_scheduler #(
  parameter logic [15:0] BASE_INTERVAL = 16'd64,
  parameter logic [15:0] MIN_INTERVAL  = 16'd8,
  parameter int          SCORE_SHIFT   = 2,
  parameter int          FIELD_W       = 20,
  parameter logic [3:0]  SPAWN_Y       = 4'd0,
  parameter logic [7:0]  ACK_TIMEOUT   = 8'd4,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] score,
  input  logic [2:0] enemy_active,
  output logic       enemy_spawn,
  output logic [4:0] enemy_init_x,
  output logic [3:0] enemy_init_y,
  output logic [7:0] spawn_count,
  output logic [7:0] drop_count,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, COUNT, SPAWN, ACK} state_t;
  state_t      state;
  logic [15:0] timer, d, ival;
  logic [7:0]  lfsr, ack_t;
  logic [5:0]  r;
  logic [4:0]  x;
  logic [1:0]  pop, snap;
  always_comb begin
    d    = 16'(score >> SCORE_SHIFT);
    ival = (BASE_INTERVAL > MIN_INTERVAL + d) ? BASE_INTERVAL - d : MIN_INTERVAL;
    r    = {1'b0, lfsr[4:0]};
    x    = 5'((r >= 6'(FIELD_W)) ? r - 6'(FIELD_W) : r);
    pop  = 2'(enemy_active[0]) + 2'(enemy_active[1]) + 2'(enemy_active[2]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      lfsr         <= LFSR_SEED;
      ack_t        <= '0;
      snap         <= '0;
      enemy_spawn  <= 1'b0;
      enemy_init_x <= '0;
      enemy_init_y <= '0;
      spawn_count  <= '0;
      drop_count   <= '0;
      busy         <= 1'b0;
    end else begin
      if (en) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      enemy_spawn <= 1'b0;
      busy        <= en;
      if (!en) state <= IDLE;
      else begin
        case (state)
          IDLE: begin
            state <= COUNT;
            timer <= ival - 16'd1;
          end
          COUNT: begin
            if (timer != '0) timer <= timer - 16'd1;
            else if (!(&enemy_active)) begin
              state        <= SPAWN;
              enemy_spawn  <= 1'b1;
              enemy_init_x <= x;
              enemy_init_y <= SPAWN_Y;
              snap         <= pop;
            end
          end
          SPAWN: begin
            state <= ACK;
            ack_t <= ACK_TIMEOUT - 8'd1;
          end
          default: begin
            // a hit freeing a slot in the same cycle masks the new one; counted as a drop
            if (pop > snap) begin
              spawn_count <= spawn_count + 8'(spawn_count != 8'hFF);
              state       <= COUNT;
              timer       <= ival - 16'd1;
            end else if (ack_t == '0) begin
              drop_count <= drop_count + 8'(drop_count != 8'hFF);
              state      <= COUNT;
              timer      <= ival - 16'd1;
            end else ack_t <= ack_t - 8'd1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spawn_scheduler.sv
// tb_spawn_scheduler: directed checks of spawn timing, LFSR x, ack/timeout counting, stall, disable and reset.
module tb_spawn_scheduler;
  logic       clk = 1'b0, rst, en;
  logic [7:0] score;
  logic [2:0] enemy_active;
  logic       enemy_spawn, busy;
  logic [4:0] enemy_init_x;
  logic [3:0] enemy_init_y;
  logic [7:0] spawn_count, drop_count;
  int n_tests = 0, n_fail = 0, exp_sc = 0, exp_dc = 0;

  always #5 clk = ~clk;

  spawn_scheduler #(.SPAWN_Y(4'd3)) dut (
    .clk(clk), .rst(rst), .en(en), .score(score), .enemy_active(enemy_active),
    .enemy_spawn(enemy_spawn), .enemy_init_x(enemy_init_x), .enemy_init_y(enemy_init_y),
    .spawn_count(spawn_count), .drop_count(drop_count), .busy(busy)
  );

  logic [7:0] m_lfsr;
  logic [4:0] m_x;

  function automatic logic [4:0] fx(input logic [7:0] l);
    logic [4:0] v;
    v = l[4:0];
    return (v >= 5'd20) ? v - 5'd20 : v;
  endfunction

  // reference LFSR: m_x is the x that would be latched at the most recent enabled edge
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_lfsr <= 8'hA5;
      m_x    <= '0;
    end else if (en) begin
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      m_x    <= fx(m_lfsr);
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_check(input int exp_period);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!enemy_spawn && c < 300);
    check("pulse_seen", enemy_spawn, 1);
    check("period", c, exp_period);
    check("x", enemy_init_x, m_x);
    check("x_range", enemy_init_x < 5'd20, 1);
    check("y", enemy_init_y, 3);
  endtask

  task automatic ack();
    @(negedge clk);
    enemy_active = 3'b001;
    @(negedge clk);
    exp_sc = (exp_sc < 255) ? exp_sc + 1 : 255;
    check("spawn_count", spawn_count, exp_sc);
    enemy_active = 3'b000;
  endtask

  initial begin
    int p;
    rst = 1'b1; en = 1'b0; score = 8'd0; enemy_active = 3'b000;
    repeat (2) @(negedge clk);
    check("rst_spawn", enemy_spawn, 0);
    check("rst_busy", busy, 0);
    check("rst_x", enemy_init_x, 0);
    check("rst_y", enemy_init_y, 0);
    check("rst_sc", spawn_count, 0);
    check("rst_dc", drop_count, 0);
    rst = 1'b0;
    @(negedge clk);
    en = 1'b1;
    pulse_check(65);
    @(negedge clk);
    check("pulse_width", enemy_spawn, 0);
    check("busy_run", busy, 1);
    repeat (3) @(negedge clk);
    check("dc_before_to", drop_count, 0);
    @(negedge clk);
    exp_dc = 1;
    check("dc_timeout", drop_count, exp_dc);
    check("sc_timeout", spawn_count, 0);
    pulse_check(64);
    score = 8'd200;
    ack();
    check("dc_hold", drop_count, exp_dc);
    pulse_check(14);
    score = 8'd255;
    ack();
    pulse_check(8);
    ack();
    enemy_active = 3'b111;
    p = 0;
    repeat (20) begin
      @(negedge clk);
      if (enemy_spawn) p++;
    end
    check("stall_no_pulse", p, 0);
    check("stall_busy", busy, 1);
    enemy_active = 3'b110;
    @(negedge clk);
    check("stall_release", enemy_spawn, 1);
    check("stall_x", enemy_init_x, m_x);
    @(negedge clk);
    enemy_active = 3'b111;
    @(negedge clk);
    exp_sc++;
    check("stall_sc", spawn_count, exp_sc);
    enemy_active = 3'b000;
    for (int i = 0; i < 1000; i++) begin
      pulse_check(8);
      ack();
    end
    check("sc_saturated", spawn_count, 255);
    check("dc_after_run", drop_count, exp_dc);
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("dis_busy", busy, 0);
    check("dis_spawn", enemy_spawn, 0);
    p = 0;
    repeat (20) begin
      @(negedge clk);
      if (enemy_spawn) p++;
    end
    check("dis_no_pulse", p, 0);
    check("dis_sc_hold", spawn_count, exp_sc);
    en = 1'b1;
    pulse_check(9);
    ack();
    pulse_check(8);
    rst = 1'b1;
    #1;
    exp_sc = 0;
    exp_dc = 0;
    check("rst_mid_spawn", enemy_spawn, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_sc", spawn_count, exp_sc);
    check("rst_mid_dc", drop_count, exp_dc);
    check("rst_mid_x", enemy_init_x, 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_check(9);
    ack();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
